// File: rtl/ctrl_encode_def.sv
// ---------------------------------------------------------------------------
// ctrl_encode_def
// Shared decoder/pipeline control encodings: next-PC ops, write-data selects,
// ALU operation codes, data-memory access types, the EX control bundle and
// the ID/EX register update selector.
// ---------------------------------------------------------------------------
package ctrl_encode_def;

    // next-PC operation
    localparam logic [2:0] NPC_PLUS4  = 3'b000;
    localparam logic [2:0] NPC_BRANCH = 3'b001;
    localparam logic [2:0] NPC_JUMP   = 3'b010;
    localparam logic [2:0] NPC_JALR   = 3'b100;

    // register write-data select
    localparam logic [1:0] WDSel_FromALU = 2'b00;
    localparam logic [1:0] WDSel_FromMEM = 2'b01;
    localparam logic [1:0] WDSel_FromPC  = 2'b10;

    // ALU operations
    localparam logic [4:0] ALUOp_nop   = 5'b00000;
    localparam logic [4:0] ALUOp_lui   = 5'b00001;
    localparam logic [4:0] ALUOp_auipc = 5'b00010;
    localparam logic [4:0] ALUOp_add   = 5'b00011;
    localparam logic [4:0] ALUOp_sub   = 5'b00100;
    localparam logic [4:0] ALUOp_beq   = 5'b00101;
    localparam logic [4:0] ALUOp_bne   = 5'b00110;
    localparam logic [4:0] ALUOp_blt   = 5'b00111;
    localparam logic [4:0] ALUOp_bge   = 5'b01000;
    localparam logic [4:0] ALUOp_bltu  = 5'b01001;
    localparam logic [4:0] ALUOp_bgeu  = 5'b01010;
    localparam logic [4:0] ALUOp_slt   = 5'b01011;
    localparam logic [4:0] ALUOp_sltu  = 5'b01100;
    localparam logic [4:0] ALUOp_xor   = 5'b01101;
    localparam logic [4:0] ALUOp_or    = 5'b01110;
    localparam logic [4:0] ALUOp_and   = 5'b01111;
    localparam logic [4:0] ALUOp_sll   = 5'b10000;
    localparam logic [4:0] ALUOp_srl   = 5'b10001;
    localparam logic [4:0] ALUOp_sra   = 5'b10010;

    // data-memory access type
    localparam logic [2:0] dm_word              = 3'b000;
    localparam logic [2:0] dm_halfword          = 3'b001;
    localparam logic [2:0] dm_halfword_unsigned = 3'b010;
    localparam logic [2:0] dm_byte              = 3'b011;
    localparam logic [2:0] dm_byte_unsigned     = 3'b100;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       mem_read;
        logic       alu_src;
        logic [4:0] alu_op;
        logic [2:0] npc_op;
        logic [1:0] wd_sel;
        logic [2:0] dm_type;
    } ex_ctrl_t;

    // Control bundle of an empty EX slot: no side effects, sequential next PC.
    localparam ex_ctrl_t CTRL_BUBBLE = '{
        reg_write: 1'b0,
        mem_write: 1'b0,
        mem_read:  1'b0,
        alu_src:   1'b0,
        alu_op:    ALUOp_nop,
        npc_op:    NPC_PLUS4,
        wd_sel:    WDSel_FromALU,
        dm_type:   dm_word
    };

    // upd sel     | meaning
    // UPD_LOAD    | capture the ID slot
    // UPD_HOLD    | freeze registers and counters
    // UPD_BUBBLE  | load-use bubble, bubble_cnt += 1
    // UPD_FLUSH   | redirect flush, flush_cnt += 1
    typedef enum logic [1:0] {
        UPD_LOAD   = 2'd0,
        UPD_HOLD   = 2'd1,
        UPD_BUBBLE = 2'd2,
        UPD_FLUSH  = 2'd3
    } upd_sel_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// ---------------------------------------------------------------------------
// id_ex_stage_if
// ID-side inputs, EX-side registered outputs and upstream control of the
// ID/EX stage.
//   master : decode/EX environment (drives id_*, ex_redirect, ex_hold)
//   slave  : id_ex_stage (drives ex_*, load_use_stall, write enables)
// ---------------------------------------------------------------------------
interface id_ex_stage_if #(parameter int XLEN = 32);

    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic [4:0]      id_rd;
    logic            id_uses_rs1;
    logic            id_uses_rs2;
    logic [XLEN-1:0] id_rd1;
    logic [XLEN-1:0] id_rd2;
    logic [XLEN-1:0] id_imm;
    logic            id_reg_write;
    logic            id_mem_write;
    logic            id_mem_read;
    logic            id_alu_src;
    logic [4:0]      id_alu_op;
    logic [2:0]      id_npc_op;
    logic [1:0]      id_wd_sel;
    logic [2:0]      id_dm_type;
    logic            ex_redirect;
    logic            ex_hold;

    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_rd1;
    logic [XLEN-1:0] ex_rd2;
    logic [XLEN-1:0] ex_imm;
    logic [4:0]      ex_rs1;
    logic [4:0]      ex_rs2;
    logic [4:0]      ex_rd;
    logic            ex_reg_write;
    logic            ex_mem_write;
    logic            ex_mem_read;
    logic            ex_alu_src;
    logic [4:0]      ex_alu_op;
    logic [2:0]      ex_npc_op;
    logic [1:0]      ex_wd_sel;
    logic [2:0]      ex_dm_type;
    logic            load_use_stall;
    logic            pc_write_en;
    logic            if_id_write_en;

    modport master (
        output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
               id_rd1, id_rd2, id_imm, id_reg_write, id_mem_write, id_mem_read,
               id_alu_src, id_alu_op, id_npc_op, id_wd_sel, id_dm_type,
               ex_redirect, ex_hold,
        input  ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd,
               ex_reg_write, ex_mem_write, ex_mem_read, ex_alu_src, ex_alu_op,
               ex_npc_op, ex_wd_sel, ex_dm_type,
               load_use_stall, pc_write_en, if_id_write_en
    );

    modport slave (
        input  id_valid, id_pc, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
               id_rd1, id_rd2, id_imm, id_reg_write, id_mem_write, id_mem_read,
               id_alu_src, id_alu_op, id_npc_op, id_wd_sel, id_dm_type,
               ex_redirect, ex_hold,
        output ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd,
               ex_reg_write, ex_mem_write, ex_mem_read, ex_alu_src, ex_alu_op,
               ex_npc_op, ex_wd_sel, ex_dm_type,
               load_use_stall, pc_write_en, if_id_write_en
    );

endinterface

// File: rtl/hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
// Combinational load-use compare between the ID instruction's sources and a
// load sitting in EX.
//   id_valid, id_rs1/2, id_uses_rs1/2 : ID instruction
//   ex_valid, ex_mem_read, ex_rd      : instruction currently in EX
//   load_use_stall                    : ID must wait one cycle
// ---------------------------------------------------------------------------
module hazard_detect (
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    output logic       load_use_stall
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_uses_rs1 & (id_rs1 == ex_rd);
    assign rs2_hit = id_uses_rs2 & (id_rs2 == ex_rd);

    // x0 is hard-wired to zero, so a load targeting it never blocks anything
    assign load_use_stall = id_valid & ex_valid & ex_mem_read & (ex_rd != 5'd0)
                          & (rs1_hit | rs2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with load-use bubble insertion, redirect flush and
// saturating bubble/flush event counters.
//   clk, rst    : rising-edge clock, asynchronous active-high reset
//   bus (slave) : id_* captured into ex_*, ex_redirect/ex_hold control,
//                 load_use_stall and pc/if_id write enables back upstream
//   bubble_cnt  : load-use bubbles inserted (saturating)
//   flush_cnt   : redirect flushes taken (saturating)
// ---------------------------------------------------------------------------
module id_ex_stage
    import ctrl_encode_def::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    id_ex_stage_if.slave     bus,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic            valid_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] rd1_q;
    logic [XLEN-1:0] rd2_q;
    logic [XLEN-1:0] imm_q;
    logic [4:0]      rs1_q;
    logic [4:0]      rs2_q;
    logic [4:0]      rd_q;
    ex_ctrl_t        ctrl_q;
    ex_ctrl_t        id_ctrl;
    logic            stall;
    logic            upstream_en;
    upd_sel_t        upd;

    assign id_ctrl = '{
        reg_write: bus.id_reg_write,
        mem_write: bus.id_mem_write,
        mem_read:  bus.id_mem_read,
        alu_src:   bus.id_alu_src,
        alu_op:    bus.id_alu_op,
        npc_op:    bus.id_npc_op,
        wd_sel:    bus.id_wd_sel,
        dm_type:   bus.id_dm_type
    };

    hazard_detect u_hazard (
        .id_valid       (bus.id_valid),
        .id_rs1         (bus.id_rs1),
        .id_rs2         (bus.id_rs2),
        .id_uses_rs1    (bus.id_uses_rs1),
        .id_uses_rs2    (bus.id_uses_rs2),
        .ex_valid       (valid_q),
        .ex_mem_read    (ctrl_q.mem_read),
        .ex_rd          (rd_q),
        .load_use_stall (stall)
    );

    // A redirect must let upstream load the new target even while stalled.
    assign upstream_en = bus.ex_redirect | ~(stall | bus.ex_hold);

    always_comb begin
        upd = UPD_LOAD;
        if (bus.ex_redirect)  upd = UPD_FLUSH;
        else if (bus.ex_hold) upd = UPD_HOLD;
        else if (stall)       upd = UPD_BUBBLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            ctrl_q  <= '0;
        end else begin
            case (upd)
                UPD_LOAD: begin
                    valid_q <= bus.id_valid;
                    pc_q    <= bus.id_pc;
                    rd1_q   <= bus.id_rd1;
                    rd2_q   <= bus.id_rd2;
                    imm_q   <= bus.id_imm;
                    rs1_q   <= bus.id_rs1;
                    rs2_q   <= bus.id_rs2;
                    rd_q    <= bus.id_rd;
                    // an empty ID slot must not carry side effects into EX
                    ctrl_q  <= bus.id_valid ? id_ctrl : CTRL_BUBBLE;
                end
                UPD_BUBBLE, UPD_FLUSH: begin
                    valid_q <= 1'b0;
                    pc_q    <= '0;
                    rd1_q   <= '0;
                    rd2_q   <= '0;
                    imm_q   <= '0;
                    rs1_q   <= '0;
                    rs2_q   <= '0;
                    rd_q    <= '0;
                    ctrl_q  <= CTRL_BUBBLE;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (upd == UPD_BUBBLE && bubble_cnt != '1)
                bubble_cnt <= bubble_cnt + CNT_ONE;
            if (upd == UPD_FLUSH && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_ONE;
        end
    end

    assign bus.ex_valid       = valid_q;
    assign bus.ex_pc          = pc_q;
    assign bus.ex_rd1         = rd1_q;
    assign bus.ex_rd2         = rd2_q;
    assign bus.ex_imm         = imm_q;
    assign bus.ex_rs1         = rs1_q;
    assign bus.ex_rs2         = rs2_q;
    assign bus.ex_rd          = rd_q;
    assign bus.ex_reg_write   = ctrl_q.reg_write;
    assign bus.ex_mem_write   = ctrl_q.mem_write;
    assign bus.ex_mem_read    = ctrl_q.mem_read;
    assign bus.ex_alu_src     = ctrl_q.alu_src;
    assign bus.ex_alu_op      = ctrl_q.alu_op;
    assign bus.ex_npc_op      = ctrl_q.npc_op;
    assign bus.ex_wd_sel      = ctrl_q.wd_sel;
    assign bus.ex_dm_type     = ctrl_q.dm_type;
    assign bus.load_use_stall = stall;
    assign bus.pc_write_en    = upstream_en;
    assign bus.if_id_write_en = upstream_en;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
// Scoreboard bench for id_ex_stage. A 4-bit-counter instance shares the same
// stimulus so counter saturation is reached in a few dozen cycles.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_write;
        logic        mem_read;
        logic        alu_src;
        logic [4:0]  alu_op;
        logic [2:0]  npc_op;
        logic [1:0]  wd_sel;
        logic [2:0]  dm_type;
    } ex_t;

    typedef struct {
        ex_t st;
        int  bub;
        int  fl;
        int  sbub;
        int  sfl;
    } exp_t;

    // {reg_write, mem_write, mem_read, alu_src, alu_op, npc_op, wd_sel, dm_type}
    localparam logic [16:0] C_ADD = {1'b1, 1'b0, 1'b0, 1'b0, 5'b00011, 3'b000, 2'b00, 3'b000};
    localparam logic [16:0] C_LW  = {1'b1, 1'b0, 1'b1, 1'b1, 5'b00011, 3'b000, 2'b01, 3'b000};

    logic        clk;
    logic        rst;
    logic [15:0] bub_cnt;
    logic [15:0] fl_cnt;
    logic [3:0]  s_bub_cnt;
    logic [3:0]  s_fl_cnt;

    int   checks;
    int   errors;
    ex_t  m;
    int   m_bub, m_fl, m_sbub, m_sfl;
    exp_t exp_q[$];

    id_ex_stage_if #(.XLEN(32)) bif ();
    id_ex_stage_if #(.XLEN(32)) sif ();

    id_ex_stage #(.XLEN(32), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bif),
        .bubble_cnt (bub_cnt),
        .flush_cnt  (fl_cnt)
    );

    id_ex_stage #(.XLEN(32), .CNT_W(4)) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .bus        (sif),
        .bubble_cnt (s_bub_cnt),
        .flush_cnt  (s_fl_cnt)
    );

    assign sif.id_valid     = bif.id_valid;
    assign sif.id_pc        = bif.id_pc;
    assign sif.id_rs1       = bif.id_rs1;
    assign sif.id_rs2       = bif.id_rs2;
    assign sif.id_rd        = bif.id_rd;
    assign sif.id_uses_rs1  = bif.id_uses_rs1;
    assign sif.id_uses_rs2  = bif.id_uses_rs2;
    assign sif.id_rd1       = bif.id_rd1;
    assign sif.id_rd2       = bif.id_rd2;
    assign sif.id_imm       = bif.id_imm;
    assign sif.id_reg_write = bif.id_reg_write;
    assign sif.id_mem_write = bif.id_mem_write;
    assign sif.id_mem_read  = bif.id_mem_read;
    assign sif.id_alu_src   = bif.id_alu_src;
    assign sif.id_alu_op    = bif.id_alu_op;
    assign sif.id_npc_op    = bif.id_npc_op;
    assign sif.id_wd_sel    = bif.id_wd_sel;
    assign sif.id_dm_type   = bif.id_dm_type;
    assign sif.ex_redirect  = bif.ex_redirect;
    assign sif.ex_hold      = bif.ex_hold;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat_inc(input int v, input int mx);
        return (v >= mx) ? mx : v + 1;
    endfunction

    function automatic ex_t sample();
        ex_t s;
        s.valid     = bif.ex_valid;
        s.pc        = bif.ex_pc;
        s.rd1       = bif.ex_rd1;
        s.rd2       = bif.ex_rd2;
        s.imm       = bif.ex_imm;
        s.rs1       = bif.ex_rs1;
        s.rs2       = bif.ex_rs2;
        s.rd        = bif.ex_rd;
        s.reg_write = bif.ex_reg_write;
        s.mem_write = bif.ex_mem_write;
        s.mem_read  = bif.ex_mem_read;
        s.alu_src   = bif.ex_alu_src;
        s.alu_op    = bif.ex_alu_op;
        s.npc_op    = bif.ex_npc_op;
        s.wd_sel    = bif.ex_wd_sel;
        s.dm_type   = bif.ex_dm_type;
        return s;
    endfunction

    task automatic compare_state(input ex_t e, input int b, input int f, input int sb, input int sf);
        ex_t o;
        o = sample();
        check("ex_data", {o.pc, o.rd1, o.rd2, o.imm}, {e.pc, e.rd1, e.rd2, e.imm});
        check("ex_idx", 128'({o.rs1, o.rs2, o.rd}), 128'({e.rs1, e.rs2, e.rd}));
        check("ex_ctrl",
              128'({o.valid, o.reg_write, o.mem_write, o.mem_read, o.alu_src,
                    o.alu_op, o.npc_op, o.wd_sel, o.dm_type}),
              128'({e.valid, e.reg_write, e.mem_write, e.mem_read, e.alu_src,
                    e.alu_op, e.npc_op, e.wd_sel, e.dm_type}));
        check("bubble_cnt", 128'(bub_cnt), 128'(b));
        check("flush_cnt", 128'(fl_cnt), 128'(f));
        check("sat_bubble_cnt", 128'(s_bub_cnt), 128'(sb));
        check("sat_flush_cnt", 128'(s_fl_cnt), 128'(sf));
    endtask

    task automatic put_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd, input logic u1,
                          input logic u2, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] imm, input logic [16:0] c);
        bif.id_valid    = v;
        bif.id_pc       = pc;
        bif.id_rs1      = rs1;
        bif.id_rs2      = rs2;
        bif.id_rd       = rd;
        bif.id_uses_rs1 = u1;
        bif.id_uses_rs2 = u2;
        bif.id_rd1      = a;
        bif.id_rd2      = b;
        bif.id_imm      = imm;
        {bif.id_reg_write, bif.id_mem_write, bif.id_mem_read, bif.id_alu_src,
         bif.id_alu_op, bif.id_npc_op, bif.id_wd_sel, bif.id_dm_type} = c;
    endtask

    // Settle current inputs, check the combinational outputs and push the
    // expected post-edge state.
    task automatic pre();
        logic st;
        logic en;
        exp_t e;
        #1;
        st = bif.id_valid & m.valid & m.mem_read & (m.rd != 5'd0)
           & ((bif.id_uses_rs1 & (bif.id_rs1 == m.rd)) | (bif.id_uses_rs2 & (bif.id_rs2 == m.rd)));
        en = bif.ex_redirect | ~(st | bif.ex_hold);
        check("load_use_stall", 128'(bif.load_use_stall), 128'(st));
        check("pc_write_en", 128'(bif.pc_write_en), 128'(en));
        check("if_id_write_en", 128'(bif.if_id_write_en), 128'(en));
        e.st = m; e.bub = m_bub; e.fl = m_fl; e.sbub = m_sbub; e.sfl = m_sfl;
        if (bif.ex_redirect) begin
            e.st  = '0;
            e.fl  = sat_inc(m_fl, 65535);
            e.sfl = sat_inc(m_sfl, 15);
        end else if (bif.ex_hold) begin
            e.st = m;
        end else if (st) begin
            e.st   = '0;
            e.bub  = sat_inc(m_bub, 65535);
            e.sbub = sat_inc(m_sbub, 15);
        end else begin
            e.st.valid = bif.id_valid;
            e.st.pc    = bif.id_pc;
            e.st.rd1   = bif.id_rd1;
            e.st.rd2   = bif.id_rd2;
            e.st.imm   = bif.id_imm;
            e.st.rs1   = bif.id_rs1;
            e.st.rs2   = bif.id_rs2;
            e.st.rd    = bif.id_rd;
            if (bif.id_valid)
                {e.st.reg_write, e.st.mem_write, e.st.mem_read, e.st.alu_src,
                 e.st.alu_op, e.st.npc_op, e.st.wd_sel, e.st.dm_type} =
                {bif.id_reg_write, bif.id_mem_write, bif.id_mem_read, bif.id_alu_src,
                 bif.id_alu_op, bif.id_npc_op, bif.id_wd_sel, bif.id_dm_type};
            else
                {e.st.reg_write, e.st.mem_write, e.st.mem_read, e.st.alu_src,
                 e.st.alu_op, e.st.npc_op, e.st.wd_sel, e.st.dm_type} = 17'd0;
        end
        exp_q.push_back(e);
    endtask

    task automatic post();
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 128'(0), 128'(1));
        end else begin
            e = exp_q.pop_front();
            compare_state(e.st, e.bub, e.fl, e.sbub, e.sfl);
            m = e.st; m_bub = e.bub; m_fl = e.fl; m_sbub = e.sbub; m_sfl = e.sfl;
        end
    endtask

    task automatic cycle();
        pre();
        post();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        compare_state('0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        compare_state('0, 0, 0, 0, 0);
        rst = 1'b0;
        m = '0; m_bub = 0; m_fl = 0; m_sbub = 0; m_sfl = 0;
        exp_q.delete();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bif.ex_redirect = 1'b0;
        bif.ex_hold     = 1'b0;
        put_id(1'b1, 32'h55, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 32'h11, 32'h22, 32'h33, C_LW);
        repeat (3) @(posedge clk);
        #1;
        do_reset();

        // pass-through, one cycle latency
        put_id(1'b1, 32'h100, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 32'd5, 32'd9, 32'h4, C_ADD);
        cycle();
        check("pt_pc", 128'(bif.ex_pc), 128'(32'h100));
        check("pt_rd1", 128'(bif.ex_rd1), 128'(32'd5));
        check("pt_alu_op", 128'(bif.ex_alu_op), 128'(5'b00011));
        check("pt_valid", 128'(bif.ex_valid), 128'(1));

        // empty ID slot: data captured, controls forced to bubble values
        put_id(1'b0, 32'h104, 5'd4, 5'd5, 5'd6, 1'b1, 1'b1, 32'd7, 32'd8, 32'd9, C_LW);
        cycle();
        check("inv_reg_write", 128'(bif.ex_reg_write), 128'(0));

        // load-use: lw x5 then add using x5
        put_id(1'b1, 32'h200, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 32'd1, 32'd0, 32'd16, C_LW);
        cycle();
        put_id(1'b1, 32'h204, 5'd5, 5'd2, 5'd6, 1'b1, 1'b1, 32'd3, 32'd4, 32'd0, C_ADD);
        pre();
        check("lu_stall", 128'(bif.load_use_stall), 128'(1));
        check("lu_pc_we", 128'(bif.pc_write_en), 128'(0));
        post();
        check("lu_bubble_valid", 128'(bif.ex_valid), 128'(0));
        check("lu_bubble_cnt", 128'(bub_cnt), 128'(1));
        pre();
        check("lu_stall_drop", 128'(bif.load_use_stall), 128'(0));
        post();
        check("lu_add_pc", 128'(bif.ex_pc), 128'(32'h204));

        // reset asserted mid-stall, then a normal first cycle
        put_id(1'b1, 32'h300, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 32'd1, 32'd0, 32'd0, C_LW);
        cycle();
        put_id(1'b1, 32'h304, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 32'd1, 32'd0, 32'd0, C_ADD);
        pre();
        exp_q.delete();
        do_reset();
        cycle();
        check("post_rst_valid", 128'(bif.ex_valid), 128'(1));

        // x0 destination and unused rs2 never stall
        put_id(1'b1, 32'h400, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 32'd1, 32'd0, 32'd0, C_LW);
        cycle();
        put_id(1'b1, 32'h404, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 32'd0, 32'd0, 32'd0, C_ADD);
        pre();
        check("x0_no_stall", 128'(bif.load_use_stall), 128'(0));
        post();
        put_id(1'b1, 32'h408, 5'd1, 5'd0, 5'd6, 1'b1, 1'b0, 32'd1, 32'd0, 32'd0, C_LW);
        cycle();
        put_id(1'b1, 32'h40c, 5'd1, 5'd6, 5'd7, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0, C_ADD);
        pre();
        check("rs2_unused_no_stall", 128'(bif.load_use_stall), 128'(0));
        post();

        // redirect together with a load-use hazard: flush only
        do_reset();
        put_id(1'b1, 32'h500, 5'd1, 5'd0, 5'd7, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0, C_LW);
        cycle();
        put_id(1'b1, 32'h504, 5'd7, 5'd0, 5'd8, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0, C_ADD);
        bif.ex_redirect = 1'b1;
        pre();
        check("fl_hazard_seen", 128'(bif.load_use_stall), 128'(1));
        check("fl_pc_we", 128'(bif.pc_write_en), 128'(1));
        post();
        bif.ex_redirect = 1'b0;
        check("fl_flush_cnt", 128'(fl_cnt), 128'(1));
        check("fl_bubble_cnt", 128'(bub_cnt), 128'(0));
        check("fl_valid", 128'(bif.ex_valid), 128'(0));

        // hold for 3 cycles with a hazard pending, then hold + redirect
        put_id(1'b1, 32'h600, 5'd1, 5'd0, 5'd9, 1'b1, 1'b0, 32'd6, 32'd0, 32'd0, C_LW);
        cycle();
        put_id(1'b1, 32'h604, 5'd9, 5'd0, 5'd10, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0, C_ADD);
        bif.ex_hold = 1'b1;
        repeat (3) cycle();
        check("hold_pc", 128'(bif.ex_pc), 128'(32'h600));
        check("hold_bubble_cnt", 128'(bub_cnt), 128'(0));
        bif.ex_redirect = 1'b1;
        cycle();
        check("hold_fl_flush_cnt", 128'(fl_cnt), 128'(2));
        bif.ex_redirect = 1'b0;
        bif.ex_hold     = 1'b0;

        // saturation: lw x5,0(x5) repeated gives a hazard every other cycle
        do_reset();
        put_id(1'b1, 32'h700, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0, C_LW);
        cycle();
        for (int i = 1; i <= 34; i++) begin
            cycle();
            if (i == 28) check("sat_preload", 128'(s_bub_cnt), 128'(4'hE));
        end
        check("sat_bubble_top", 128'(s_bub_cnt), 128'(4'hF));
        check("bubble_17", 128'(bub_cnt), 128'(17));
        bif.ex_redirect = 1'b1;
        repeat (20) cycle();
        bif.ex_redirect = 1'b0;
        check("sat_flush_top", 128'(s_fl_cnt), 128'(4'hF));
        check("flush_20", 128'(fl_cnt), 128'(20));

        // random traffic against the scoreboard
        for (int i = 0; i < 300; i++) begin
            put_id(1'($urandom_range(0, 3) != 0), $urandom, 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom, $urandom, $urandom, 17'($urandom));
            bif.ex_redirect = ($urandom_range(0, 7) == 0);
            bif.ex_hold     = ($urandom_range(0, 5) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register with integrated load-use hazard detection and bubble/flush insertion.
- Sits directly downstream of the instruction decoder: captures its control outputs together with register-file operands, immediate, PC and register indices, and presents them to the EX stage.
- Drives the PC and IF/ID write enables back upstream.
- Keeps saturating counters of inserted bubbles and flushes for performance monitoring.

Parameters:
- XLEN, 32, datapath width (PC, operands, immediate).
- CNT_W, 16, width of the bubble and flush counters.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- id_valid  in  1  ID slot holds a real instruction
- id_pc  in  XLEN  PC of the ID instruction
- id_rs1, id_rs2, id_rd  in  5 each  register indices
- id_uses_rs1, id_uses_rs2  in  1 each  instruction reads rs1/rs2
- id_rd1, id_rd2  in  XLEN each  register-file read data
- id_imm  in  XLEN  extended immediate
- id_reg_write, id_mem_write, id_mem_read, id_alu_src  in  1 each  decoder controls
- id_alu_op  in  5  ALU operation
- id_npc_op  in  3  next-PC operation
- id_wd_sel  in  2  write-data select
- id_dm_type  in  3  data-memory access type
- ex_redirect  in  1  EX resolved a taken branch or jump; flush younger instructions
- ex_hold  in  1  downstream stall; freeze ID/EX
- ex_valid  out  1  EX slot holds a real instruction
- ex_pc, ex_rd1, ex_rd2, ex_imm  out  XLEN each  registered copies
- ex_rs1, ex_rs2, ex_rd  out  5 each  registered copies
- ex_reg_write, ex_mem_write, ex_mem_read, ex_alu_src, ex_alu_op, ex_npc_op, ex_wd_sel, ex_dm_type  out  as inputs  registered controls
- load_use_stall  out  1  combinational hazard flag
- pc_write_en, if_id_write_en  out  1 each  upstream write enables
- bubble_cnt, flush_cnt  out  CNT_W each  saturating event counters

Behaviour:
- Reset (asynchronous, immediate): every ex_* output is 0, ex_valid=0, both counters are 0.
- Hazard, combinational:
  - load_use_stall = id_valid & ex_valid & ex_mem_read & (ex_rd!=0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
  - pc_write_en = if_id_write_en = ~(load_use_stall | ex_hold).
  - A flush overrides both enables: when ex_redirect=1, both enables are 1 so that upstream can load the redirect target.
- Register update on the clock edge, in priority order:
  1. ex_redirect=1: load a bubble; flush_cnt += 1.
  2. ex_hold=1: all ID/EX registers and counters hold.
  3. load_use_stall=1: load a bubble; bubble_cnt += 1.
  4. Otherwise: load every id_* field; ex_valid <= id_valid.
- Bubble definition:
  - ex_valid, ex_reg_write, ex_mem_write, ex_mem_read are 0; ex_npc_op=000 (PLUS4); ex_wd_sel=00.
  - ex_alu_op=0 and ex_dm_type=0. Data/index fields are 0.
- id_valid=0 on a normal load also forces the control fields to the bubble values.
- Invariant: ex_valid=0 implies reg_write, mem_write, mem_read and npc_op are all 0.
- Latency: one cycle from ID to EX.
- A load-use stall lasts exactly one cycle: the inserted bubble clears ex_mem_read, so the hazard drops on the next cycle.
- Register x0 is never a hazard.
- Simultaneous events:
  - redirect + hazard: flush only; bubble_cnt unchanged.
  - redirect + hold: flush wins.
  - hold + hazard: hold; no counter change.
- Counters saturate at all-ones and never wrap.
- Reset asserted mid-stall or mid-flush returns to the reset state immediately. The first edge after release behaves as a normal cycle.

Decomposition:
- Shared package/include ctrl_encode_def holds the constants:
  - NPC_PLUS4/BRANCH/JUMP/JALR (000/001/010/100)
  - WDSel_FromALU/MEM/PC (00/01/10)
  - ALUOp_* codes
  - dm_word..dm_byte_unsigned (000..100)
- The bubble value is composed from these constants.
- Sub-module hazard_detect: purely combinational load-use compare, instantiated once.

Test Plan:
- Reset: pulse rst with clk running and id_valid=1 -> all ex_* = 0, counters 0. Hold rst high while id_valid=1: outputs stay 0 with no clk dependence.
- Pass-through: id_pc=0x100, id_rd1=5, id_alu_op=00011, id_reg_write=1 -> one cycle later ex_pc=0x100, ex_rd1=5, ex_alu_op=00011, ex_valid=1.
- Load-use:
  - Stimulus: lw to x5 in EX (ex_mem_read=1, ex_rd=5), then add using rs1=5 in ID.
  - Response: load_use_stall=1, pc_write_en=0. Next cycle ex_valid=0 and bubble_cnt=1. The following cycle the add enters EX with load_use_stall=0.
- x0/unused source: ex_rd=0 with ex_mem_read=1, or matching rs2 with id_uses_rs2=0 -> no stall.
- Flush priority: ex_redirect=1 together with a load-use hazard -> bubble loaded, flush_cnt=1, bubble_cnt=0, pc_write_en=1.
- Hold and saturation:
  - ex_hold=1 for 3 cycles -> ex_* and counters frozen.
  - Preload bubble_cnt to 0xFFFE, then apply 3 hazards -> count reads 0xFFFF.
